// File: rtl/pc_sequencer.sv
// Next-PC sequencer: decodes the fetched MIPS word and steers the program counter
// through jumps, two-cycle conditional branches and memory waits with a bounded timeout.
module pc_sequencer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    input  logic             instr_valid,
    input  logic             alu_zero,
    input  logic             mem_busy,
    output logic             pc_branch,
    output logic [31:0]      branch_offset,
    output logic             pc_jump,
    output logic [25:0]      jump_target,
    output logic             pc_hold,
    output logic             busy,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] retired_count,
    output logic [CNT_W-1:0] taken_count
);

    localparam int                WAIT_W    = $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    localparam logic [5:0] OP_J   = 6'h02;
    localparam logic [5:0] OP_JAL = 6'h03;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic [1:0] {
        FETCH,
        BR_EVAL,
        MEM_WAIT
    } state_t;

    state_t            state, state_nxt;
    logic              is_bne;
    logic [WAIT_W-1:0] wait_cnt;
    logic [5:0]        op;

    logic retire;
    logic taken;
    logic capture_branch;
    logic start_wait;
    logic wait_inc;
    logic timeout_hit;

    assign op = instr[31:26];

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_nxt      = state;
        pc_branch      = 1'b0;
        pc_jump        = 1'b0;
        pc_hold        = 1'b0;
        retire         = 1'b0;
        taken          = 1'b0;
        capture_branch = 1'b0;
        start_wait     = 1'b0;
        wait_inc       = 1'b0;
        timeout_hit    = 1'b0;

        unique case (state)
            FETCH: begin
                if (!instr_valid) begin
                    pc_hold = 1'b1;
                end else begin
                    case (op)
                        OP_J, OP_JAL: begin
                            pc_jump = 1'b1;
                            retire  = 1'b1;
                        end
                        OP_BEQ, OP_BNE: begin
                            pc_hold        = 1'b1;
                            capture_branch = 1'b1;
                            state_nxt      = BR_EVAL;
                        end
                        OP_LW, OP_SW: begin
                            pc_hold    = 1'b1;
                            start_wait = 1'b1;
                            state_nxt  = MEM_WAIT;
                        end
                        default: retire = 1'b1;
                    endcase
                end
            end
            BR_EVAL: begin
                taken     = alu_zero ^ is_bne;
                pc_branch = taken;
                retire    = 1'b1;
                state_nxt = FETCH;
            end
            MEM_WAIT: begin
                if (!mem_busy) begin
                    retire    = 1'b1;
                    state_nxt = FETCH;
                end else if (wait_cnt != WAIT_LAST) begin
                    pc_hold  = 1'b1;
                    wait_inc = 1'b1;
                end else begin
                    // Memory never released: give up on this access and move on.
                    timeout_hit = 1'b1;
                    retire      = 1'b1;
                    state_nxt   = FETCH;
                end
            end
            default: state_nxt = FETCH;
        endcase

        if (rst) begin
            pc_branch = 1'b0;
            pc_jump   = 1'b0;
            pc_hold   = 1'b0;
        end
    end

    assign jump_target = pc_jump ? instr[25:0] : 26'd0;
    assign busy        = (state != FETCH);

    always_ff @(posedge clk) begin
        // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state         <= FETCH;
            branch_offset <= '0;
            is_bne        <= 1'b0;
            wait_cnt      <= '0;
            mem_timeout   <= 1'b0;
            retired_count <= '0;
            taken_count   <= '0;
        end else begin
            state <= state_nxt;
            if (capture_branch) begin
                branch_offset <= {{16{instr[15]}}, instr[15:0]};
                is_bne        <= op[0];
            end
            if (start_wait) begin
                wait_cnt <= '0;
            end else if (wait_inc) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
            if (timeout_hit) begin
                mem_timeout <= 1'b1;
            end
            if (retire) begin
                retired_count <= retired_count + CNT_W'(1);
            end
            taken_count <= taken_count + CNT_W'(taken);
        end
    end

endmodule
